// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/DIV op through start pulse, done wait, and HI/LO commit or exception
module muldiv_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic op_valid,
  input  logic op_sel,
  output logic op_ready,
  output logic busy,
  output logic mult_start,
  output logic div_start,
  input  logic mult_fim,
  input  logic div_fim,
  input  logic div_by_zero,
  output logic hi_sel,
  output logic lo_sel,
  output logic hi_write,
  output logic lo_write,
  output logic done,
  output logic exc_div0,
  output logic exc_timeout
);
  typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, EXC} state_t;
  state_t state;
  logic op_q;
  logic [CNT_W-1:0] cnt;
  logic fim;
  assign fim = op_q ? div_fim : mult_fim;
  assign hi_sel = op_q;
  assign lo_sel = op_q;
  // outputs are registered alongside the state they belong to
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op_q <= 1'b0;
      cnt <= '0;
      op_ready <= 1'b1;
      busy <= 1'b0;
      mult_start <= 1'b0;
      div_start <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      done <= 1'b0;
      exc_div0 <= 1'b0;
      exc_timeout <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start <= 1'b0;
      hi_write <= 1'b0;
      lo_write <= 1'b0;
      done <= 1'b0;
      exc_div0 <= 1'b0;
      exc_timeout <= 1'b0;
      op_ready <= 1'b0;
      busy <= 1'b1;
      case (state)
        IDLE: begin
          if (op_valid) begin
            state <= START;
            op_q <= op_sel;
            cnt <= '0;
            mult_start <= ~op_sel;
            div_start <= op_sel;
          end else begin
            op_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
          if (fim) begin
            if (op_q && div_by_zero) begin
              state <= EXC;
              exc_div0 <= 1'b1;
            end else begin
              state <= WRITE;
              hi_write <= 1'b1;
              lo_write <= 1'b1;
              done <= 1'b1;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= IDLE;
            exc_timeout <= 1'b1;
            op_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          op_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scenario tasks plus a scoreboard of expected completions checked by a negedge monitor
module tb_muldiv_ctrl;
  localparam int TIMEOUT = 40;
  localparam int CNT_W = 6;
  localparam logic [1:0] K_DONE = 2'd0, K_DIV0 = 2'd1, K_TO = 2'd2;
  logic clock = 1'b0;
  logic reset = 1'b0, op_valid = 1'b0, op_sel = 1'b0;
  logic mult_fim = 1'b0, div_fim = 1'b0, div_by_zero = 1'b0;
  logic op_ready, busy, mult_start, div_start, hi_sel, lo_sel;
  logic hi_write, lo_write, done, exc_div0, exc_timeout;
  int vectors = 0, miscompares = 0;
  bit armed = 1'b0;
  typedef struct packed {logic [1:0] kind; logic sel;} exp_t;
  exp_t sb[$];

  muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_sel(op_sel),
    .op_ready(op_ready), .busy(busy), .mult_start(mult_start), .div_start(div_start),
    .mult_fim(mult_fim), .div_fim(div_fim), .div_by_zero(div_by_zero),
    .hi_sel(hi_sel), .lo_sel(lo_sel), .hi_write(hi_write), .lo_write(lo_write),
    .done(done), .exc_div0(exc_div0), .exc_timeout(exc_timeout)
  );

  always #5 clock = ~clock;

  // scoreboard side: every completion strobe must match the oldest expected outcome
  always @(negedge clock) begin
    if (armed) begin
      vectors++;
      if ((mult_start && div_start) || ($countones({done, exc_div0, exc_timeout}) > 1) ||
          (hi_write !== done) || (lo_write !== done)) begin
        miscompares++;
        $display("FAIL invariant: ms=%b ds=%b done=%b div0=%b to=%b hw=%b lw=%b",
                 mult_start, div_start, done, exc_div0, exc_timeout, hi_write, lo_write);
      end
      if (done || exc_div0 || exc_timeout) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_completion: done=%b div0=%b to=%b with nothing expected",
                   done, exc_div0, exc_timeout);
        end else begin
          exp_t e;
          logic [1:0] k;
          e = sb.pop_front();
          k = done ? K_DONE : exc_div0 ? K_DIV0 : K_TO;
          if ({k, hi_sel, lo_sel} !== {e.kind, e.sel, e.sel}) begin
            miscompares++;
            $display("FAIL scoreboard: got kind=%0d sel=%b%b expected kind=%0d sel=%b",
                     k, hi_sel, lo_sel, e.kind, e.sel);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic accept(input logic sel, input bit push, input logic [1:0] kind);
    op_valid = 1'b1;
    op_sel = sel;
    if (push) sb.push_back(exp_t'({kind, sel}));
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if ({op_ready, busy, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, done, exc_div0, exc_timeout}
        !== 11'b100_0000_0000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 10000000000",
               {op_ready, busy, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, done, exc_div0, exc_timeout});
    end
    armed = 1'b1;
  endtask

  task automatic test_mult();
    accept(1'b0, 1'b1, K_DONE);
    vectors++;
    if ({mult_start, div_start, busy, op_ready} !== 4'b1010) begin
      miscompares++;
      $display("FAIL mult_start: got ms/ds/busy/rdy=%b expected 1010", {mult_start, div_start, busy, op_ready});
    end
    for (int i = 1; i < 34; i++) begin
      step();
      vectors++;
      if ({mult_start, div_start, busy, done} !== 4'b0010) begin
        miscompares++;
        $display("FAIL mult_wait: cycle %0d got ms/ds/busy/done=%b expected 0010", i, {mult_start, div_start, busy, done});
      end
    end
    mult_fim = 1'b1;
    step();
    mult_fim = 1'b0;
    vectors++;
    if ({hi_write, lo_write, done, hi_sel, lo_sel, op_ready} !== 6'b111000) begin
      miscompares++;
      $display("FAIL mult_write: got hw/lw/done/hs/ls/rdy=%b expected 111000", {hi_write, lo_write, done, hi_sel, lo_sel, op_ready});
    end
    step();
    vectors++;
    if ({op_ready, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL mult_idle: got rdy/busy/done=%b expected 100", {op_ready, busy, done});
    end
  endtask

  task automatic test_div();
    accept(1'b1, 1'b1, K_DONE);
    vectors++;
    if ({mult_start, div_start, hi_sel} !== 3'b011) begin
      miscompares++;
      $display("FAIL div_start: got ms/ds/hs=%b expected 011", {mult_start, div_start, hi_sel});
    end
    repeat (33) begin
      mult_fim = ~mult_fim;
      step();
    end
    mult_fim = 1'b0;
    div_fim = 1'b1;
    step();
    div_fim = 1'b0;
    vectors++;
    if ({hi_write, lo_write, done, hi_sel, lo_sel, exc_div0} !== 6'b111110) begin
      miscompares++;
      $display("FAIL div_write: got hw/lw/done/hs/ls/div0=%b expected 111110", {hi_write, lo_write, done, hi_sel, lo_sel, exc_div0});
    end
    step();
    vectors++;
    if ({op_ready, hi_sel, lo_sel} !== 3'b111) begin
      miscompares++;
      $display("FAIL div_hold_sel: got rdy/hs/ls=%b expected 111", {op_ready, hi_sel, lo_sel});
    end
  endtask

  task automatic test_div0();
    accept(1'b1, 1'b1, K_DIV0);
    step();
    step();
    div_fim = 1'b1;
    div_by_zero = 1'b1;
    step();
    vectors++;
    if ({exc_div0, done, hi_write, lo_write} !== 4'b1000) begin
      miscompares++;
      $display("FAIL div0_exc: got div0/done/hw/lw=%b expected 1000", {exc_div0, done, hi_write, lo_write});
    end
    step();
    div_fim = 1'b0;
    div_by_zero = 1'b0;
    vectors++;
    if ({exc_div0, done, op_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL div0_idle: got div0/done/rdy=%b expected 001", {exc_div0, done, op_ready});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    accept(1'b0, 1'b1, K_TO);
    while (!exc_timeout && n < 100) begin
      div_fim = ~div_fim;
      div_by_zero = div_fim;
      step();
      n++;
    end
    div_fim = 1'b0;
    div_by_zero = 1'b0;
    vectors++;
    if (n + 1 !== TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL timeout_latency: exc_timeout at cycle %0d expected %0d", n + 1, TIMEOUT + 2);
    end
    vectors++;
    if ({op_ready, busy, exc_timeout} !== 3'b101) begin
      miscompares++;
      $display("FAIL timeout_idle: got rdy/busy/to=%b expected 101", {op_ready, busy, exc_timeout});
    end
    step();
    vectors++;
    if ({exc_timeout, op_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL timeout_pulse: got to/rdy=%b expected 01", {exc_timeout, op_ready});
    end
  endtask

  task automatic test_back_to_back();
    accept(1'b0, 1'b1, K_DONE);
    repeat (5) step();
    op_valid = 1'b1;
    op_sel = 1'b1;
    step();
    step();
    op_valid = 1'b0;
    op_sel = 1'b0;
    vectors++;
    if ({div_start, hi_sel, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL busy_ignore: got ds/hs/busy=%b expected 001", {div_start, hi_sel, busy});
    end
    repeat (10) step();
    op_valid = 1'b1;
    op_sel = 1'b1;
    sb.push_back(exp_t'({K_DONE, 1'b1}));
    mult_fim = 1'b1;
    step();
    mult_fim = 1'b0;
    vectors++;
    if ({done, hi_sel} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_first_done: got done/hs=%b expected 10", {done, hi_sel});
    end
    step();
    vectors++;
    if ({op_ready, div_start} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_no_bypass: got rdy/ds=%b expected 10", {op_ready, div_start});
    end
    step();
    op_valid = 1'b0;
    vectors++;
    if ({div_start, mult_start, hi_sel, op_ready} !== 4'b1010) begin
      miscompares++;
      $display("FAIL b2b_accept: got ds/ms/hs/rdy=%b expected 1010", {div_start, mult_start, hi_sel, op_ready});
    end
    div_fim = 1'b1;
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_start_ignores_fim: got done=%b expected 0", done);
    end
    step();
    div_fim = 1'b0;
    vectors++;
    if ({done, hi_sel} !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_min_latency: got done/hs=%b expected 11", {done, hi_sel});
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    accept(1'b0, 1'b0, K_DONE);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({op_ready, busy, mult_start, div_start, hi_write, done, exc_div0, exc_timeout} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_mid_op: got %b expected 10000000",
               {op_ready, busy, mult_start, div_start, hi_write, done, exc_div0, exc_timeout});
    end
    mult_fim = 1'b1;
    step();
    step();
    mult_fim = 1'b0;
    vectors++;
    if ({done, hi_write, busy, op_ready} !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_late_fim: got done/hw/busy/rdy=%b expected 0001", {done, hi_write, busy, op_ready});
    end
  endtask

  initial begin
    step();
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    repeat (3) step();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d outcomes never seen, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
